// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher.
// Exports: state_e (IDLE/HIGH/LOW encoding), timer_width() for sizing the
// phase timer from the high/low durations.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Bits needed to hold max(high, low) - 1; never less than one bit so a
  // 1-cycle/1-cycle configuration still gets a legal vector.
  function automatic int timer_width(input int high_cycles, input int low_cycles);
    int m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretch_cycle_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the last cycle of
// a phase. Ports: clk_i, rst_i (async, active-high), load_i/load_val_i
// (load wins over decrement), zero_o (count == 0).
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into HIGH_CYCLES-wide pulses separated by at
// least LOW_CYCLES low cycles, queueing up to PEND_MAX extra events.
// Ports: clk, reset (async, active-high), in (event strobe), out (registered
// pulse), busy (state != IDLE), pending (queued events), overflow (sticky drop).
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_MAX    = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in,
  output logic                            out,
  output logic                            busy,
  output logic [$clog2(PEND_MAX+1)-1:0]   pending,
  output logic                            overflow
);

  localparam int TW = timer_width(HIGH_CYCLES, LOW_CYCLES);
  localparam int PW = $clog2(PEND_MAX + 1);

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  state_e        state_q, state_d;
  logic          out_q, out_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // One extra bit so pending + in cannot wrap when the queue is full.
  logic [PW:0]   net;

  cycle_timer #(.W(TW)) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign net = {1'b0, pending_q} + (PW+1)'(in);

  always_comb begin
    state_d    = state_q;
    out_d      = 1'b0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d  = ST_HIGH;
          out_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HIGH_LOAD;
        end
      end

      ST_HIGH: begin
        out_d = 1'b1;
        if (in) begin
          if (pending_q != PEND_FULL) pending_d = pending_q + PW'(1);
          else                        overflow_d = 1'b1;
        end
        if (tmr_zero) begin
          state_d  = ST_LOW;
          out_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LOW_LOAD;
        end
      end

      ST_LOW: begin
        if (tmr_zero) begin
          // Last gap cycle: an event arriving now is consumed directly, so
          // it starts the next pulse without ever occupying a queue slot.
          if (net != '0) begin
            state_d   = ST_HIGH;
            out_d     = 1'b1;
            pending_d = PW'(net - (PW+1)'(1));
            tmr_load  = 1'b1;
            tmr_val   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (in) begin
          if (pending_q != PEND_FULL) pending_d = pending_q + PW'(1);
          else                        overflow_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
